note_sequencer: RTL

- Paces song playback for the game datapath.
- While the game mode is RUN, it counts beats at a difficulty-selected tempo, fetches one 4-lane note word per beat from song memory, and presents it to the note/display pipeline.
- Produces `note_count`, which feeds the mode state machine's end-of-song detection. Sits between the mode FSM and song ROM.

---
 rtl/note_sequencer_if.sv | 12 +
 rtl/note_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// Song memory bus between the note sequencer and the song ROM.
//   mem_rd   : one-cycle read strobe from the sequencer
//   mem_addr : note index to read (valid while mem_rd is high)
//   mem_data : 4 lane bits returned by the ROM the cycle after mem_rd
interface note_sequencer_if;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [3:0] mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/note_sequencer.sv
// Song playback pacer. While the game mode is RUN it counts beats at a tempo
// chosen by the difficulty latched on RUN entry, fetches one 4-lane note word
// per beat from song memory and presents it to the note/display pipeline.
//
// Ports:
//   clk, rst    : 12 MHz clock, asynchronous active-high reset
//   mode        : game mode (1 IDLE, 2 EDIT, 3 DIFF, 4 RUN, 5 PAUSE, 6 FINISH)
//   difficulty  : tempo select, sampled only on IDLE->RUN entry
//   mem         : song memory bus (read strobe, address, returned data)
//   beat        : one-cycle pulse at each beat boundary
//   note_out    : last fetched note lanes
//   note_valid  : one-cycle pulse when note_out updates
//   note_count  : notes issued so far, saturates at SONG_LEN
//   done        : level, song complete or skipped to FINISH
module note_sequencer #(
    parameter int SONG_LEN  = 41,
    parameter int BEAT_EASY = 6000000,
    parameter int BEAT_MED  = 4500000,
    parameter int BEAT_HARD = 3000000,
    parameter int CNT_W     = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mode,
    input  logic [1:0]            difficulty,
    note_sequencer_if.master      mem,
    output logic                  beat,
    output logic [3:0]            note_out,
    output logic                  note_valid,
    output logic [5:0]            note_count,
    output logic                  done
);

    localparam logic [2:0] M_IDLE   = 3'd1;
    localparam logic [2:0] M_EDIT   = 3'd2;
    localparam logic [2:0] M_DIFF   = 3'd3;
    localparam logic [2:0] M_RUN    = 3'd4;
    localparam logic [2:0] M_FINISH = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_LATCH,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   period_sel;
    logic               mem_rd_q;
    logic               counting;
    logic               wrap;
    logic [5:0]         count_inc;

    always_comb begin
        period_sel = CNT_W'(BEAT_HARD);
        case (difficulty)
            2'd0:    period_sel = CNT_W'(BEAT_EASY);
            2'd1:    period_sel = CNT_W'(BEAT_MED);
            default: period_sel = CNT_W'(BEAT_HARD);
        endcase
    end

    // The counter keeps running through FETCH/LATCH so the beat grid does not
    // slip by the two fetch cycles; PAUSE (or any non-RUN mode) freezes it.
    assign counting  = (mode == M_RUN) &&
                       (state == S_WAIT || state == S_FETCH || state == S_LATCH);
    assign wrap      = counting && (beat_cnt == period - CNT_W'(1));
    assign count_inc = note_count + 6'd1;

    // note_count does not move between WAIT and FETCH, so it doubles as the
    // read address.
    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = note_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            period     <= '0;
            beat       <= 1'b0;
            mem_rd_q   <= 1'b0;
            note_out   <= '0;
            note_valid <= 1'b0;
            note_count <= '0;
            done       <= 1'b0;
        end else begin
            beat       <= 1'b0;
            mem_rd_q   <= 1'b0;
            note_valid <= 1'b0;

            if (counting) begin
                if (wrap) begin
                    beat_cnt <= '0;
                    beat     <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    note_count <= '0;
                    beat_cnt   <= '0;
                    note_out   <= '0;
                    done       <= 1'b0;
                    if (mode == M_RUN) begin
                        period <= period_sel;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    case (mode)
                        M_RUN: begin
                            if (wrap) begin
                                mem_rd_q <= 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                        // Skip to end: keep the count reached so far.
                        M_FINISH: begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                        M_IDLE, M_EDIT, M_DIFF: begin
                            note_count <= '0;
                            beat_cnt   <= '0;
                            note_out   <= '0;
                            done       <= 1'b0;
                            state      <= S_IDLE;
                        end
                        // PAUSE and unused codes: hold everything.
                        default: ;
                    endcase
                end

                // Fetch is atomic: FETCH and LATCH always complete whatever
                // the mode does; the new mode is honoured back in WAIT.
                S_FETCH: state <= S_LATCH;

                S_LATCH: begin
                    note_out   <= mem.mem_data;
                    note_valid <= 1'b1;
                    note_count <= count_inc;
                    if (count_inc == 6'(SONG_LEN)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_DONE: begin
                    if (mode == M_IDLE) begin
                        note_count <= '0;
                        note_out   <= '0;
                        done       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
